// File: rtl/wordle_pkg.sv
// Shared widths, ASCII codes, colour codes and state encodings for the Wordle guess path.
package wordle_pkg;

    localparam int unsigned WORD_LEN = 5;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned WORD_W   = WORD_LEN * CHAR_W;
    localparam int unsigned SCORE_W  = WORD_LEN * COL_W;
    localparam int unsigned ST_W     = 5;
    localparam int unsigned PH_W     = 3;

    localparam logic [CHAR_W-1:0] ASCII_BS   = 8'h08;
    localparam logic [CHAR_W-1:0] ASCII_CR   = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_UA   = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_UZ   = 8'h5A;
    localparam logic [CHAR_W-1:0] ASCII_LA   = 8'h61;
    localparam logic [CHAR_W-1:0] ASCII_LZ   = 8'h7A;
    localparam logic [CHAR_W-1:0] ASCII_CASE = 8'h20;

    localparam logic [COL_W-1:0] COL_GREY   = 2'b00;
    localparam logic [COL_W-1:0] COL_YELLOW = 2'b01;
    localparam logic [COL_W-1:0] COL_GREEN  = 2'b10;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
    localparam logic [IDX_W-1:0] CUR_FULL = IDX_W'(WORD_LEN);

    // Top-level handshake states, one-hot to match the game SM
    localparam logic [ST_W-1:0] ST_IDLE    = 5'b00001;
    localparam logic [ST_W-1:0] ST_ENTRY   = 5'b00010;
    localparam logic [ST_W-1:0] ST_SCORE_G = 5'b00100;
    localparam logic [ST_W-1:0] ST_SCORE_Y = 5'b01000;
    localparam logic [ST_W-1:0] ST_PRESENT = 5'b10000;

    // Score engine phases
    localparam logic [PH_W-1:0] PH_IDLE   = 3'b001;
    localparam logic [PH_W-1:0] PH_GREEN  = 3'b010;
    localparam logic [PH_W-1:0] PH_YELLOW = 3'b100;

    typedef logic [WORD_LEN-1:0][CHAR_W-1:0] word_t;
    typedef logic [WORD_LEN-1:0][COL_W-1:0]  score_t;

    // Letter 0 sits in the most significant slot of a packed word
    function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] idx);
        return LAST_IDX - idx;
    endfunction

endpackage

// File: rtl/wordle_score_engine.sv
// Multi-cycle Wordle scorer: 5-cycle green pass then 25-cycle yellow pass with a used-letter mask.
module wordle_score_engine
    import wordle_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic [WORD_W-1:0]  i_guess,
    input  logic [WORD_W-1:0]  i_target,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_done,
    output logic               o_in_yellow
);

    logic [PH_W-1:0]     r_phase;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [WORD_LEN-1:0] r_used;
    score_t              r_score;
    logic                r_matched;
    logic                r_done;

    logic [PH_W-1:0]     w_phase_nxt;
    logic [IDX_W-1:0]    w_i_nxt;
    logic [IDX_W-1:0]    w_j_nxt;
    logic [WORD_LEN-1:0] w_used_nxt;
    score_t              w_score_nxt;
    logic                w_matched_nxt;
    logic                w_done_nxt;

    word_t               w_guess;
    word_t               w_target;
    logic                w_hit_green;
    logic                w_hit_yellow;

    assign w_guess  = i_guess;
    assign w_target = i_target;

    assign w_hit_green  = (w_guess[slot(r_i)] == w_target[slot(r_i)]);
    // A guess letter earns yellow once, from the lowest unused target position
    assign w_hit_yellow = (r_score[slot(r_i)] != COL_GREEN) && !r_used[r_j] && !r_matched
                          && (w_guess[slot(r_i)] == w_target[slot(r_j)]);

    always_comb begin
        w_phase_nxt   = r_phase;
        w_i_nxt       = r_i;
        w_j_nxt       = r_j;
        w_used_nxt    = r_used;
        w_score_nxt   = r_score;
        w_matched_nxt = r_matched;
        w_done_nxt    = 1'b0;
        if (i_clear) begin
            w_phase_nxt   = PH_IDLE;
            w_i_nxt       = '0;
            w_j_nxt       = '0;
            w_used_nxt    = '0;
            w_score_nxt   = '0;
            w_matched_nxt = 1'b0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (i_start) begin
                        w_phase_nxt   = PH_GREEN;
                        w_i_nxt       = '0;
                        w_j_nxt       = '0;
                        w_used_nxt    = '0;
                        w_score_nxt   = '0;
                        w_matched_nxt = 1'b0;
                    end
                end
                PH_GREEN: begin
                    if (w_hit_green) begin
                        w_score_nxt[slot(r_i)] = COL_GREEN;
                        w_used_nxt[r_i]        = 1'b1;
                    end
                    if (r_i == LAST_IDX) begin
                        w_phase_nxt   = PH_YELLOW;
                        w_i_nxt       = '0;
                        w_j_nxt       = '0;
                        w_matched_nxt = 1'b0;
                    end else begin
                        w_i_nxt = r_i + IDX_W'(1);
                    end
                end
                PH_YELLOW: begin
                    if (w_hit_yellow) begin
                        w_score_nxt[slot(r_i)] = COL_YELLOW;
                        w_used_nxt[r_j]        = 1'b1;
                        w_matched_nxt          = 1'b1;
                    end
                    if (r_j == LAST_IDX) begin
                        w_j_nxt       = '0;
                        w_matched_nxt = 1'b0;
                        if (r_i == LAST_IDX) begin
                            w_phase_nxt = PH_IDLE;
                            w_i_nxt     = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_i_nxt = r_i + IDX_W'(1);
                        end
                    end else begin
                        w_j_nxt = r_j + IDX_W'(1);
                    end
                end
                default: begin
                    w_phase_nxt = PH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase   <= PH_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_used    <= '0;
            r_score   <= '0;
            r_matched <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_used    <= w_used_nxt;
            r_score   <= w_score_nxt;
            r_matched <= w_matched_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_score     = r_score;
    assign o_done      = r_done;
    assign o_in_yellow = (r_phase == PH_YELLOW);

endmodule

// File: rtl/wordle_guess_ctrl.sv
// Keyboard entry buffer, guess scoring sequencer and valid/ack presentation to the game SM.
module wordle_guess_ctrl
    import wordle_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_round_start,
    input  logic [WORD_W-1:0]  i_target_word,
    input  logic               i_key_valid,
    input  logic [CHAR_W-1:0]  i_key_code,
    output logic               o_key_ready,
    output logic [IDX_W-1:0]   o_cursor,
    output logic               o_reject,
    output logic               o_guess_valid,
    input  logic               i_guess_ack,
    output logic [WORD_W-1:0]  o_guess_word,
    output logic [SCORE_W-1:0] o_guess_score,
    output logic               o_win,
    output logic               o_busy
);

    logic [ST_W-1:0]  r_state;
    word_t            r_target;
    word_t            r_buf;
    logic [IDX_W-1:0] r_cursor;
    logic             r_key_ready;
    logic             r_busy;
    logic             r_guess_valid;
    logic             r_win;
    logic             r_reject;

    logic [ST_W-1:0]  w_state_nxt;
    word_t            w_target_nxt;
    word_t            w_buf_nxt;
    logic [IDX_W-1:0] w_cursor_nxt;
    logic             w_win_nxt;
    logic             w_reject_nxt;
    logic             w_start_c;
    logic             w_clear_c;

    logic             w_is_upper;
    logic             w_is_lower;
    logic [CHAR_W-1:0] w_letter;
    logic [SCORE_W-1:0] w_score;
    logic             w_done;
    logic             w_in_yellow;

    assign w_is_upper = (i_key_code >= ASCII_UA) && (i_key_code <= ASCII_UZ);
    assign w_is_lower = (i_key_code >= ASCII_LA) && (i_key_code <= ASCII_LZ);
    assign w_letter   = w_is_lower ? (i_key_code - ASCII_CASE) : i_key_code;

    wordle_score_engine u_score (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_start_c),
        .i_clear     (w_clear_c),
        .i_guess     (r_buf),
        .i_target    (r_target),
        .o_score     (w_score),
        .o_done      (w_done),
        .o_in_yellow (w_in_yellow)
    );

    // Next-state and datapath updates; round_start overrides every state
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_buf_nxt    = r_buf;
        w_cursor_nxt = r_cursor;
        w_win_nxt    = r_win;
        w_reject_nxt = 1'b0;
        w_start_c    = 1'b0;
        w_clear_c    = 1'b0;
        if (i_round_start) begin
            w_state_nxt  = ST_ENTRY;
            w_target_nxt = i_target_word;
            w_buf_nxt    = '0;
            w_cursor_nxt = '0;
            w_clear_c    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ENTRY: begin
                    if (i_key_valid) begin
                        if (w_is_upper || w_is_lower) begin
                            if (r_cursor != CUR_FULL) begin
                                w_buf_nxt[slot(r_cursor)] = w_letter;
                                w_cursor_nxt              = r_cursor + IDX_W'(1);
                            end
                        end else if (i_key_code == ASCII_BS) begin
                            if (r_cursor != '0) begin
                                w_cursor_nxt                  = r_cursor - IDX_W'(1);
                                w_buf_nxt[slot(w_cursor_nxt)] = '0;
                            end
                        end else if (i_key_code == ASCII_CR) begin
                            if (r_cursor == CUR_FULL) begin
                                w_state_nxt = ST_SCORE_G;
                                w_start_c   = 1'b1;
                            end else begin
                                w_reject_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_SCORE_G: begin
                    if (w_in_yellow) begin
                        w_state_nxt = ST_SCORE_Y;
                    end
                end
                ST_SCORE_Y: begin
                    if (w_done) begin
                        w_state_nxt = ST_PRESENT;
                        w_win_nxt   = (w_score == {WORD_LEN{COL_GREEN}});
                    end
                end
                ST_PRESENT: begin
                    if (i_guess_ack) begin
                        w_state_nxt  = ST_ENTRY;
                        w_buf_nxt    = '0;
                        w_cursor_nxt = '0;
                        w_clear_c    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        if (w_state_nxt != ST_PRESENT) begin
            w_win_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            r_buf         <= '0;
            r_cursor      <= '0;
            r_key_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_guess_valid <= 1'b0;
            r_win         <= 1'b0;
            r_reject      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_target      <= w_target_nxt;
            r_buf         <= w_buf_nxt;
            r_cursor      <= w_cursor_nxt;
            r_key_ready   <= (w_state_nxt == ST_ENTRY);
            r_busy        <= (w_state_nxt == ST_SCORE_G) || (w_state_nxt == ST_SCORE_Y)
                             || (w_state_nxt == ST_PRESENT);
            r_guess_valid <= (w_state_nxt == ST_PRESENT);
            r_win         <= w_win_nxt;
            r_reject      <= w_reject_nxt;
        end
    end

    assign o_key_ready   = r_key_ready;
    assign o_cursor      = r_cursor;
    assign o_reject      = r_reject;
    assign o_guess_valid = r_guess_valid;
    assign o_guess_word  = r_buf;
    assign o_guess_score = w_score;
    assign o_win         = r_win;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Scoreboard bench: stimulus queues expected guesses, a monitor checks each presented guess.
module tb_wordle_guess_ctrl;

    logic        clk;
    logic        rst_n;
    logic        round_start;
    logic [39:0] target_word;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ready;
    logic [2:0]  cursor;
    logic        reject;
    logic        guess_valid;
    logic        guess_ack;
    logic [39:0] guess_word;
    logic [9:0]  guess_score;
    logic        win;
    logic        busy;

    typedef struct {
        logic [39:0] word;
        logic [9:0]  score;
        logic        win;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_total;
    int   n_bad;
    int   cyc;

    localparam logic [7:0] K_BS = 8'h08;
    localparam logic [7:0] K_CR = 8'h0D;

    wordle_guess_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_round_start (round_start),
        .i_target_word (target_word),
        .i_key_valid   (key_valid),
        .i_key_code    (key_code),
        .o_key_ready   (key_ready),
        .o_cursor      (cursor),
        .o_reject      (reject),
        .o_guess_valid (guess_valid),
        .i_guess_ack   (guess_ack),
        .o_guess_word  (guess_word),
        .o_guess_score (guess_score),
        .o_win         (win),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented guess against the oldest expectation
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (guess_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_guess", 64'(guess_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("guess_word", 64'(guess_word), 64'(e.word));
                    check("guess_score", 64'(guess_score), 64'(e.score));
                    check("guess_win", 64'(win), 64'(e.win));
                    check("guess_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_valid = guess_valid;
        end
    end

    task automatic key(input logic [7:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic start_round(input logic [39:0] t);
        @(negedge clk);
        round_start = 1'b1;
        target_word = t;
        @(negedge clk);
        round_start = 1'b0;
    endtask

    task automatic type_word(input logic [39:0] w);
        for (int k = 0; k < 5; k++) key(w[39-8*k -: 8]);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!guess_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 64'(guess_valid), 64'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        guess_ack = 1'b1;
        @(negedge clk);
        guess_ack = 1'b0;
        check("ack_valid_low", 64'(guess_valid), 64'd0);
        check("ack_cursor", 64'(cursor), 64'd0);
        check("ack_key_ready", 64'(key_ready), 64'd1);
        check("ack_word_clr", 64'(guess_word), 64'd0);
    endtask

    // Type a guess, press enter, queue the expected result, then wait and acknowledge
    task automatic submit(input logic [39:0] w, input logic [9:0] s, input logic wn);
        exp_t e;
        type_word(w);
        key(K_CR);
        e.word  = w;
        e.score = s;
        e.win   = wn;
        e.cyc   = cyc + 31;
        sb.push_back(e);
        check("scoring_busy", 64'({busy, key_ready}), 64'b10);
        key("Q");
        check("scoring_key_dropped", 64'(guess_word), 64'(w));
        wait_valid();
        ack();
    endtask

    initial begin
        int hold_err;
        cyc         = 0;
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        round_start = 1'b0;
        target_word = '0;
        key_valid   = 1'b0;
        key_code    = '0;
        guess_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({key_ready, cursor, reject, guess_valid, win, busy, guess_score}), 64'd0);
        check("reset_word", 64'(guess_word), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_ready", 64'(key_ready), 64'd0);

        // 1: exact match
        start_round("ROBOT");
        check("entry_ready", 64'({key_ready, cursor}), 64'b1000);
        submit("ROBOT", 10'b1010101010, 1'b1);

        // 2: mixed greens and yellows
        submit("BOOST", 10'b0110010010, 1'b0);

        // 3: surplus duplicates stay grey
        start_round("ABBOT");
        submit("BBBBB", 10'b0010100000, 1'b0);

        // 4: lowercase, backspace, overflow, reject
        start_round("ROBOT");
        key("r");
        key("X");
        check("two_letters", 64'({cursor, guess_word}), {21'd0, 3'd2, "RX", 24'd0});
        key(K_BS);
        check("backspace", 64'({cursor, guess_word}), {21'd0, 3'd1, "R", 32'd0});
        type_word("obot?");
        check("lower_to_upper", 64'({cursor, guess_word}), {21'd0, 3'd5, "ROBOT"});
        key("Z");
        check("sixth_ignored", 64'({cursor, guess_word}), {21'd0, 3'd5, "ROBOT"});
        begin
            exp_t e;
            key(K_CR);
            e.word = "ROBOT"; e.score = 10'b1010101010; e.win = 1'b1; e.cyc = cyc + 31;
            sb.push_back(e);
            wait_valid();
            ack();
        end
        key(K_BS);
        check("bs_at_zero", 64'(cursor), 64'd0);
        @(negedge clk);
        guess_ack = 1'b1;
        @(negedge clk);
        guess_ack = 1'b0;
        key("1");
        check("ack_and_junk_ignored", 64'({key_ready, cursor}), 64'b1000);
        type_word("ABC??");
        key(K_CR);
        check("reject_pulse", 64'({reject, cursor, guess_valid, key_ready}), 64'b101101);
        @(negedge clk);
        check("reject_one_cycle", 64'(reject), 64'd0);
        repeat (40) @(negedge clk);
        check("no_valid_after_reject", 64'({guess_valid, busy}), 64'd0);
        key(K_BS); key(K_BS); key(K_BS);
        check("cleared_by_bs", 64'({cursor, guess_word}), 64'd0);

        // 5: target sampled only at round_start, long hold, abort in PRESENT
        start_round("CRANE");
        target_word = "ROBOT";
        begin
            exp_t e;
            type_word("CRANE");
            key(K_CR);
            e.word = "CRANE"; e.score = 10'b1010101010; e.win = 1'b1; e.cyc = cyc + 31;
            sb.push_back(e);
        end
        wait_valid();
        hold_err = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            key_valid = k[0];
            key_code  = "A";
            if ({guess_valid, win, cursor, guess_word, guess_score} !== {1'b1, 1'b1, 3'd5, 40'("CRANE"), 10'b1010101010})
                hold_err++;
        end
        key_valid = 1'b0;
        check("hold_stable", 64'(hold_err), 64'd0);
        @(negedge clk);
        round_start = 1'b1;
        guess_ack   = 1'b1;
        @(negedge clk);
        round_start = 1'b0;
        guess_ack   = 1'b0;
        check("abort_present", 64'({guess_valid, win, busy, key_ready, cursor}), 64'b0001000);
        check("abort_word_score", 64'({guess_word, guess_score}), 64'd0);

        // 6: async reset in the yellow pass
        start_round("ROBOT");
        type_word("ROBOT");
        key(K_CR);
        repeat (12) @(negedge clk);
        check("mid_score_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", 64'({key_ready, cursor, reject, guess_valid, win, busy, guess_score}), 64'd0);
        check("async_reset_word", 64'(guess_word), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        key("A");
        repeat (40) @(negedge clk);
        check("idle_after_reset", 64'({key_ready, cursor, busy, guess_valid}), 64'd0);
        start_round("ROBOT");
        check("ready_after_round", 64'(key_ready), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
